aib_link_init_ctrl: RTL and testbench



---
 rtl/aib_link_init_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_aib_link_init_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aib_link_init_ctrl.sv
// ----------------------------------------------------------------------------
// aib_link_init_ctrl
//   Bring-up sequencer for one AIB Gen2 PHY instance and its AXI-MM bridge.
//   The sequence is: program NUM_CFG PHY registers over AVMM, release the
//   adapter reset after RST_HOLD cycles, raise the DCC/DLL lock requests, wait
//   for the transfer enables, assert MAC-ready, wait for far-side ready and RX
//   alignment, then raise link_up. Losing far-side ready or alignment while
//   the link is up drops the link and restarts from the reset-release step.
//
//   Optional feature macro: AIB_INIT_TIMEOUT_EN
//     defined   - watchdog of TIMEOUT_CYCLES per wait state, ERROR reachable
//     undefined - wait states wait forever, init_err tied to 0
//
// Ports
//   i_cfg_avmm_clk          clock
//   i_cfg_avmm_rst_n        asynchronous active-low reset
//   start                   level enable, 0 returns to IDLE
//   cfg_addr_tbl            NUM_CFG x 17-bit AVMM addresses (entry k at [17k+:17])
//   cfg_data_tbl            NUM_CFG x AVMM_WIDTH write data
//   o_avmm_addr/write/wdata/byte_en, i_avmm_waitreq   AVMM write master
//   ns_adapter_rstn, ns_mac_rdy, *_dcc_dll_lock_req   per-channel PHY control
//   ms_tx/rx_transfer_en, fs_mac_rdy, m_rx_align_done  async PHY status
//   link_up                 link operational
//   init_err                watchdog expired, sticky until start=0
//   state_o                 current state encoding
// ----------------------------------------------------------------------------
module aib_link_init_ctrl #(
    parameter int NBR_CHNLS      = 24,
    parameter int NUM_CFG        = 4,
    parameter int AVMM_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 4,
    parameter int RST_HOLD       = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          i_cfg_avmm_clk,
    input  logic                          i_cfg_avmm_rst_n,
    input  logic                          start,
    input  logic [NUM_CFG*17-1:0]         cfg_addr_tbl,
    input  logic [NUM_CFG*AVMM_WIDTH-1:0] cfg_data_tbl,
    output logic [16:0]                   o_avmm_addr,
    output logic                          o_avmm_write,
    output logic [AVMM_WIDTH-1:0]         o_avmm_wdata,
    output logic [BYTE_WIDTH-1:0]         o_avmm_byte_en,
    input  logic                          i_avmm_waitreq,
    output logic [NBR_CHNLS-1:0]          ns_adapter_rstn,
    output logic [NBR_CHNLS-1:0]          ns_mac_rdy,
    output logic [NBR_CHNLS-1:0]          ms_rx_dcc_dll_lock_req,
    output logic [NBR_CHNLS-1:0]          ms_tx_dcc_dll_lock_req,
    output logic [NBR_CHNLS-1:0]          sl_rx_dcc_dll_lock_req,
    output logic [NBR_CHNLS-1:0]          sl_tx_dcc_dll_lock_req,
    input  logic [NBR_CHNLS-1:0]          ms_tx_transfer_en,
    input  logic [NBR_CHNLS-1:0]          ms_rx_transfer_en,
    input  logic [NBR_CHNLS-1:0]          fs_mac_rdy,
    input  logic [NBR_CHNLS-1:0]          m_rx_align_done,
    output logic                          link_up,
    output logic                          init_err,
    output logic [3:0]                    state_o
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        CFG_WR     = 4'd1,
        CFG_GAP    = 4'd2,
        RST_REL    = 4'd3,
        LOCK_REQ   = 4'd4,
        WAIT_XFER  = 4'd5,
        WAIT_FS    = 4'd6,
        WAIT_ALIGN = 4'd7,
        LINK_UP    = 4'd8,
        ERROR      = 4'd9
    } state_t;

    localparam int IDX_W  = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;
`ifdef AIB_INIT_TIMEOUT_EN
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W  = (TO_W > HOLD_W) ? TO_W : HOLD_W;
`else
    localparam int CNT_W  = HOLD_W;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CFG - 1);

    // ------------------------------------------------------------------
    // Status synchronizers (2 flops) and channel AND-reduction
    // ------------------------------------------------------------------
    logic [NBR_CHNLS-1:0] txen_s1_q, txen_s2_q;
    logic [NBR_CHNLS-1:0] rxen_s1_q, rxen_s2_q;
    logic [NBR_CHNLS-1:0] fsrdy_s1_q, fsrdy_s2_q;
    logic [NBR_CHNLS-1:0] align_s1_q, align_s2_q;

    always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
        if (!i_cfg_avmm_rst_n) begin
            txen_s1_q  <= '0;
            txen_s2_q  <= '0;
            rxen_s1_q  <= '0;
            rxen_s2_q  <= '0;
            fsrdy_s1_q <= '0;
            fsrdy_s2_q <= '0;
            align_s1_q <= '0;
            align_s2_q <= '0;
        end else begin
            txen_s1_q  <= ms_tx_transfer_en;
            txen_s2_q  <= txen_s1_q;
            rxen_s1_q  <= ms_rx_transfer_en;
            rxen_s2_q  <= rxen_s1_q;
            fsrdy_s1_q <= fs_mac_rdy;
            fsrdy_s2_q <= fsrdy_s1_q;
            align_s1_q <= m_rx_align_done;
            align_s2_q <= align_s1_q;
        end
    end

    logic xfer_ok, fs_ok, align_ok;
    assign xfer_ok  = (&txen_s2_q) & (&rxen_s2_q);
    assign fs_ok    = &fsrdy_s2_q;
    assign align_ok = &align_s2_q;

    // ------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [16:0]           addr_q, addr_d;
    logic [AVMM_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rstn_q, rstn_d;
    logic                  lock_q, lock_d;
    logic                  mac_q, mac_d;
    logic                  link_q, link_d;
    logic                  timeout_hit;
    logic                  cnt_run;
    logic [16:0]           tbl_addr;
    logic [AVMM_WIDTH-1:0] tbl_data;

`ifdef AIB_INIT_TIMEOUT_EN
    logic err_q, err_d;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Table entry selected by the next index, so a fresh write starts with
    // the right address on the same edge that enters CFG_WR.
    always_comb begin
        tbl_addr = '0;
        tbl_data = '0;
        for (int unsigned k = 0; k < NUM_CFG; k++) begin
            if (idx_d == IDX_W'(k)) begin
                tbl_addr = cfg_addr_tbl[k*17 +: 17];
                tbl_data = cfg_data_tbl[k*AVMM_WIDTH +: AVMM_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CFG_WR;
                    idx_d   = '0;
                end
            end
            CFG_WR: begin
                if (!i_avmm_waitreq) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = RST_REL;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = CFG_GAP;
                    end
                end else if (timeout_hit) begin
                    state_d = ERROR;
                end
            end
            CFG_GAP:  state_d = CFG_WR;
            RST_REL: begin
                if (cnt_q == CNT_W'(RST_HOLD - 1)) state_d = LOCK_REQ;
            end
            LOCK_REQ: state_d = WAIT_XFER;
            WAIT_XFER: begin
                if (xfer_ok)          state_d = WAIT_FS;
                else if (timeout_hit) state_d = ERROR;
            end
            WAIT_FS: begin
                if (fs_ok)            state_d = WAIT_ALIGN;
                else if (timeout_hit) state_d = ERROR;
            end
            WAIT_ALIGN: begin
                if (align_ok)         state_d = LINK_UP;
                else if (timeout_hit) state_d = ERROR;
            end
            LINK_UP: begin
                // Link loss restarts from reset release; config is kept.
                if (!(fs_ok && align_ok)) state_d = RST_REL;
            end
            ERROR:    state_d = ERROR;
            default:  state_d = IDLE;
        endcase

        if (!start) begin
            state_d = IDLE;
            idx_d   = '0;
        end

        // Counter is shared by the reset hold and the watchdog; it restarts
        // on every state entry.
`ifdef AIB_INIT_TIMEOUT_EN
        cnt_run = (state_q == RST_REL)   || (state_q == CFG_WR)  ||
                  (state_q == WAIT_XFER) || (state_q == WAIT_FS) ||
                  (state_q == WAIT_ALIGN);
`else
        cnt_run = (state_q == RST_REL);
`endif
        if (state_d != state_q) cnt_d = '0;
        else if (cnt_run)       cnt_d = cnt_q + 1'b1;
        else                    cnt_d = cnt_q;

        // Outputs are registered from the next state so they change on the
        // same edge as the state; an in-flight write holds its payload.
        write_d = (state_d == CFG_WR);
        if (state_d == CFG_WR && state_q == CFG_WR) begin
            addr_d  = addr_q;
            wdata_d = wdata_q;
        end else if (state_d == CFG_WR) begin
            addr_d  = tbl_addr;
            wdata_d = tbl_data;
        end else begin
            addr_d  = '0;
            wdata_d = '0;
        end
        rstn_d = (state_d == LOCK_REQ) || (state_d == WAIT_XFER) ||
                 (state_d == WAIT_FS)  || (state_d == WAIT_ALIGN) ||
                 (state_d == LINK_UP);
        lock_d = rstn_d;
        mac_d  = (state_d == WAIT_FS) || (state_d == WAIT_ALIGN) ||
                 (state_d == LINK_UP);
        link_d = (state_d == LINK_UP);
`ifdef AIB_INIT_TIMEOUT_EN
        err_d  = (state_d == ERROR);
`endif
    end

    always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
        if (!i_cfg_avmm_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rstn_q  <= 1'b0;
            lock_q  <= 1'b0;
            mac_q   <= 1'b0;
            link_q  <= 1'b0;
`ifdef AIB_INIT_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rstn_q  <= rstn_d;
            lock_q  <= lock_d;
            mac_q   <= mac_d;
            link_q  <= link_d;
`ifdef AIB_INIT_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign o_avmm_addr            = addr_q;
    assign o_avmm_write           = write_q;
    assign o_avmm_wdata           = wdata_q;
    assign o_avmm_byte_en         = {BYTE_WIDTH{write_q}};
    assign ns_adapter_rstn        = {NBR_CHNLS{rstn_q}};
    assign ns_mac_rdy             = {NBR_CHNLS{mac_q}};
    assign ms_rx_dcc_dll_lock_req = {NBR_CHNLS{lock_q}};
    assign ms_tx_dcc_dll_lock_req = {NBR_CHNLS{lock_q}};
    assign sl_rx_dcc_dll_lock_req = {NBR_CHNLS{lock_q}};
    assign sl_tx_dcc_dll_lock_req = {NBR_CHNLS{lock_q}};
    assign link_up                = link_q;
    assign state_o                = state_q;
`ifdef AIB_INIT_TIMEOUT_EN
    assign init_err               = err_q;
`else
    assign init_err               = 1'b0;
`endif

endmodule

// File: tb/tb_aib_link_init_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aib_link_init_ctrl
//   Directed, table-driven bench for aib_link_init_ctrl (NUM_CFG=4,
//   RST_HOLD=8, TIMEOUT_CYCLES=100). Each vector drives the inputs for one
//   cycle and lists the outputs expected one edge later. Channel-wide buses
//   are folded to one bit plus a uniformity flag.
// ----------------------------------------------------------------------------
module tb_aib_link_init_ctrl;

    localparam int N  = 24;
    localparam int NC = 4;
    localparam int AW = 32;
    localparam int BW = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [NC*17-1:0]   addr_tbl;
    logic [NC*AW-1:0]   data_tbl;
    logic [16:0]        o_addr;
    logic               o_wr;
    logic [AW-1:0]      o_wd;
    logic [BW-1:0]      o_be;
    logic               wreq = 1'b0;
    logic [N-1:0]       rstn, mrdy, mrx, mtx, srx, stx;
    logic [N-1:0]       txen = '0, rxen = '0, fsr = '0, aln = '0;
    logic               link, err;
    logic [3:0]         st;

    logic [N-1:0]       fs_kill = '0;
    logic [N-1:0]       al_kill = '0;

    logic [16:0] ca [NC] = '{17'h0A03C, 17'h1B7F0, 17'h00208, 17'h1FFFC};
    logic [31:0] cd [NC] = '{32'hDEAD_0001, 32'h1234_5678, 32'hA5A5_5A5A, 32'h0F0F_F0F0};

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aib_link_init_ctrl #(
        .NBR_CHNLS(N), .NUM_CFG(NC), .AVMM_WIDTH(AW), .BYTE_WIDTH(BW),
        .RST_HOLD(8), .TIMEOUT_CYCLES(100)
    ) dut (
        .i_cfg_avmm_clk(clk), .i_cfg_avmm_rst_n(rst_n), .start(start),
        .cfg_addr_tbl(addr_tbl), .cfg_data_tbl(data_tbl),
        .o_avmm_addr(o_addr), .o_avmm_write(o_wr), .o_avmm_wdata(o_wd),
        .o_avmm_byte_en(o_be), .i_avmm_waitreq(wreq),
        .ns_adapter_rstn(rstn), .ns_mac_rdy(mrdy),
        .ms_rx_dcc_dll_lock_req(mrx), .ms_tx_dcc_dll_lock_req(mtx),
        .sl_rx_dcc_dll_lock_req(srx), .sl_tx_dcc_dll_lock_req(stx),
        .ms_tx_transfer_en(txen), .ms_rx_transfer_en(rxen),
        .fs_mac_rdy(fsr), .m_rx_align_done(aln),
        .link_up(link), .init_err(err), .state_o(st)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic        wr;
        logic [16:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rstn, lock, mac, link, err, uni;
    } obs_t;

    typedef struct {
        logic start, wq, xf, fs, al;
        obs_t exp;
    } vec_t;

    vec_t tbl[$];

    function automatic obs_t ob(int s, int idx, bit r, bit l, bit m, bit lk, bit e);
        obs_t o;
        o.st = 4'(s);
        o.wr = (idx >= 0);
        o.addr = '0;
        o.wd = '0;
        o.be = '0;
        if (idx >= 0) begin
            o.addr = ca[idx];
            o.wd   = cd[idx];
            o.be   = '1;
        end
        o.rstn = r; o.lock = l; o.mac = m; o.link = lk; o.err = e; o.uni = 1'b1;
        return o;
    endfunction

    function automatic obs_t obz(int s);          return ob(s, -1, 0, 0, 0, 0, 0); endfunction
    function automatic obs_t obw(int idx);        return ob(1, idx, 0, 0, 0, 0, 0); endfunction
    function automatic obs_t obl(int s, bit m, bit lk); return ob(s, -1, 1, 1, m, lk, 0); endfunction

    function automatic vec_t V(bit s, bit wq, bit xf, bit fs, bit al, obs_t e);
        vec_t v;
        v.start = s; v.wq = wq; v.xf = xf; v.fs = fs; v.al = al; v.exp = e;
        return v;
    endfunction

    function automatic bit uni(logic [N-1:0] b);
        return (b === '0) || (b === '1);
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = st; o.wr = o_wr; o.addr = o_addr; o.wd = o_wd; o.be = o_be;
        o.rstn = &rstn;
        o.lock = &{mrx, mtx, srx, stx};
        o.mac  = &mrdy;
        o.link = link;
        o.err  = err;
        o.uni  = uni(rstn) && uni(mrdy) && uni(mrx) && uni(mtx) && uni(srx) && uni(stx);
        return o;
    endfunction

    task automatic check(obs_t e, string nm);
        obs_t a;
        a = sample();
        // AVMM payload is only defined while writing or in IDLE.
        if (!e.wr && e.st != 4'd0) begin
            a.addr = '0; a.wd = '0; a.be = '0;
        end
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got st=%0d wr=%b addr=%h wd=%h be=%h rstn=%b lock=%b mac=%b link=%b err=%b uni=%b | want st=%0d wr=%b addr=%h wd=%h be=%h rstn=%b lock=%b mac=%b link=%b err=%b uni=%b",
                     nm, a.st, a.wr, a.addr, a.wd, a.be, a.rstn, a.lock, a.mac, a.link, a.err, a.uni,
                     e.st, e.wr, e.addr, e.wd, e.be, e.rstn, e.lock, e.mac, e.link, e.err, e.uni);
        end
    endtask

    task automatic apply(vec_t v, string nm);
        start = v.start;
        wreq  = v.wq;
        txen  = {N{v.xf}};
        rxen  = {N{v.xf}};
        fsr   = {N{v.fs}} & ~fs_kill;
        aln   = {N{v.al}} & ~al_kill;
        @(posedge clk);
        #1;
        check(v.exp, nm);
    endtask

    initial begin
        for (int k = 0; k < NC; k++) begin
            addr_tbl[k*17 +: 17] = ca[k];
            data_tbl[k*AW +: AW] = cd[k];
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check(obz(0), "reset_state");
        rst_n = 1'b1;
        apply(V(0, 0, 0, 0, 0, obz(0)), "idle_no_start");

        // Main bring-up: 4 writes, 8-cycle reset hold, status in sequence
        tbl.push_back(V(1, 0, 0, 0, 0, obw(0)));
        tbl.push_back(V(1, 0, 0, 0, 0, obz(2)));
        tbl.push_back(V(1, 0, 0, 0, 0, obw(1)));
        tbl.push_back(V(1, 0, 0, 0, 0, obz(2)));
        tbl.push_back(V(1, 0, 0, 0, 0, obw(2)));
        tbl.push_back(V(1, 0, 0, 0, 0, obz(2)));
        tbl.push_back(V(1, 0, 0, 0, 0, obw(3)));
        tbl.push_back(V(1, 0, 0, 0, 0, obz(3)));
        for (int k = 0; k < 7; k++) tbl.push_back(V(1, 0, 0, 0, 0, obz(3)));
        tbl.push_back(V(1, 0, 0, 0, 0, obl(4, 0, 0)));
        tbl.push_back(V(1, 0, 0, 0, 0, obl(5, 0, 0)));
        tbl.push_back(V(1, 0, 1, 0, 0, obl(5, 0, 0)));
        tbl.push_back(V(1, 0, 1, 0, 0, obl(5, 0, 0)));
        tbl.push_back(V(1, 0, 1, 0, 0, obl(6, 1, 0)));
        tbl.push_back(V(1, 0, 1, 1, 0, obl(6, 1, 0)));
        tbl.push_back(V(1, 0, 1, 1, 0, obl(6, 1, 0)));
        tbl.push_back(V(1, 0, 1, 1, 0, obl(7, 1, 0)));
        tbl.push_back(V(1, 0, 1, 1, 1, obl(7, 1, 0)));
        tbl.push_back(V(1, 0, 1, 1, 1, obl(7, 1, 0)));
        tbl.push_back(V(1, 0, 1, 1, 1, obl(8, 1, 1)));
        tbl.push_back(V(1, 0, 1, 1, 1, obl(8, 1, 1)));
        foreach (tbl[i]) apply(tbl[i], $sformatf("main[%0d]", i));

        // Link loss on fs_mac_rdy[5]: back to RST_REL, no AVMM write
        fs_kill[5] = 1'b1;
        apply(V(1, 0, 1, 1, 1, obl(8, 1, 1)), "loss_sync1");
        apply(V(1, 0, 1, 1, 1, obl(8, 1, 1)), "loss_sync2");
        apply(V(1, 0, 1, 1, 1, obz(3)), "loss_drop");
        for (int k = 0; k < 7; k++) apply(V(1, 0, 1, 1, 1, obz(3)), $sformatf("loss_hold[%0d]", k));
        apply(V(1, 0, 1, 1, 1, obl(4, 0, 0)), "loss_lockreq");
        apply(V(1, 0, 1, 1, 1, obl(5, 0, 0)), "loss_wxfer");
        for (int k = 0; k < 4; k++) apply(V(1, 0, 1, 1, 1, obl(6, 1, 0)), $sformatf("loss_wfs[%0d]", k));

        // Restore fs, but hold one channel's alignment low: no link_up
        fs_kill = '0;
        al_kill[17] = 1'b1;
        apply(V(1, 0, 1, 1, 1, obl(6, 1, 0)), "fs_back_s1");
        apply(V(1, 0, 1, 1, 1, obl(6, 1, 0)), "fs_back_s2");
        for (int k = 0; k < 9; k++) apply(V(1, 0, 1, 1, 1, obl(7, 1, 0)), $sformatf("align_missing[%0d]", k));
        al_kill = '0;
        apply(V(1, 0, 1, 1, 1, obl(7, 1, 0)), "align_back_s1");
        apply(V(1, 0, 1, 1, 1, obl(7, 1, 0)), "align_back_s2");
        apply(V(1, 0, 1, 1, 1, obl(8, 1, 1)), "relink");

        // start=0 aborts to IDLE
        apply(V(0, 0, 1, 1, 1, obz(0)), "abort_idle");

        // waitreq stall on entry 2: payload stable for 6 cycles
        apply(V(1, 0, 1, 0, 1, obw(0)), "stall_w0");
        apply(V(1, 0, 1, 0, 1, obz(2)), "stall_g0");
        apply(V(1, 0, 1, 0, 1, obw(1)), "stall_w1");
        apply(V(1, 0, 1, 0, 1, obz(2)), "stall_g1");
        apply(V(1, 0, 1, 0, 1, obw(2)), "stall_w2");
        for (int k = 0; k < 5; k++) apply(V(1, 1, 1, 0, 1, obw(2)), $sformatf("stall_hold[%0d]", k));
        apply(V(1, 0, 1, 0, 1, obz(2)), "stall_accept");
        apply(V(1, 0, 1, 0, 1, obw(3)), "stall_w3");
        apply(V(1, 0, 1, 0, 1, obz(3)), "stall_rst");
        for (int k = 0; k < 7; k++) apply(V(1, 0, 1, 0, 1, obz(3)), $sformatf("stall_rsthold[%0d]", k));
        apply(V(1, 0, 1, 0, 1, obl(4, 0, 0)), "stall_lockreq");
        apply(V(1, 0, 1, 0, 1, obl(5, 0, 0)), "stall_wxfer");
        for (int k = 0; k < 3; k++) apply(V(1, 0, 1, 0, 1, obl(6, 1, 0)), $sformatf("stall_wfs[%0d]", k));

        // Asynchronous reset in WAIT_FS
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check(obz(0), "async_reset");
        @(posedge clk);
        #1;
        check(obz(0), "reset_hold");
        rst_n = 1'b1;
        apply(V(0, 0, 0, 0, 0, obz(0)), "post_reset_idle");

        // Transfer enables never arrive
        apply(V(1, 0, 0, 0, 0, obw(0)), "to_w0");
        apply(V(1, 0, 0, 0, 0, obz(2)), "to_g0");
        apply(V(1, 0, 0, 0, 0, obw(1)), "to_w1");
        apply(V(1, 0, 0, 0, 0, obz(2)), "to_g1");
        apply(V(1, 0, 0, 0, 0, obw(2)), "to_w2");
        apply(V(1, 0, 0, 0, 0, obz(2)), "to_g2");
        apply(V(1, 0, 0, 0, 0, obw(3)), "to_w3");
        for (int k = 0; k < 8; k++) apply(V(1, 0, 0, 0, 0, obz(3)), $sformatf("to_rst[%0d]", k));
        apply(V(1, 0, 0, 0, 0, obl(4, 0, 0)), "to_lockreq");
        apply(V(1, 0, 0, 0, 0, obl(5, 0, 0)), "to_wxfer_entry");
`ifdef AIB_INIT_TIMEOUT_EN
        for (int k = 0; k < 99; k++) apply(V(1, 0, 0, 0, 0, obl(5, 0, 0)), $sformatf("to_wait[%0d]", k));
        apply(V(1, 0, 0, 0, 0, ob(9, -1, 0, 0, 0, 0, 1)), "to_error");
        apply(V(1, 0, 0, 0, 0, ob(9, -1, 0, 0, 0, 0, 1)), "to_error_sticky");
`else
        for (int k = 0; k < 150; k++) apply(V(1, 0, 0, 0, 0, obl(5, 0, 0)), $sformatf("to_wait[%0d]", k));
`endif
        apply(V(0, 0, 0, 0, 0, obz(0)), "to_clear_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
